if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port stall  input  2  stall[0]=hold PC, stall[1]=hold IF/ID register.
REQ-004 SHALL have port flush  input  1  exception flush request.
REQ-005 SHALL have port flush_pc  input  16  restart byte address on flush.
REQ-006 SHALL have port branch_flag  input  1  taken branch from ID.
REQ-007 SHALL have port branch_target  input  16  branch byte address.
REQ-008 SHALL have port rom_addr  output  16  instruction byte address to ROM.
REQ-009 SHALL have port rom_we  output  1  ROM write-enable, tied to `ChipRead level.
REQ-010 SHALL have port rom_inst  input  16  instruction returned combinationally by ROM.
REQ-011 SHALL have port id_pc  output  16  registered PC of instruction held for ID.
REQ-012 SHALL have port id_inst  output  16  registered instruction for ID.
REQ-013 SHALL have port id_valid  output  1  id_inst is a real fetched instruction, not a bubble.
REQ-014 SHALL have port fetch_fault  output  1  registered one-cycle misaligned-redirect pulse.

Function
REQ-015 SHALL implement states IDLE, RUN; IDLE lasts exactly one cycle after rst deasserts, then RUN.
REQ-016 SHALL drive rom_addr = pc combinationally in RUN; rom_addr = 0x0000 in IDLE.
REQ-017 SHALL, in RUN with stall=2'b00 and no flush/branch: id_inst<=rom_inst, id_pc<=pc, id_valid<=1, pc<=pc+2.
REQ-018 SHALL wrap pc+2 from 0xFFFE to 0x0000 with no flag.
REQ-019 SHALL, when stall=2'b11, hold pc, id_pc, id_inst, id_valid unchanged.
REQ-020 SHALL, when stall=2'b01, hold pc and load bubble: id_inst<=0x0000, id_valid<=0, id_pc<=pc.
REQ-021 SHALL treat stall=2'b10 as 2'b11 (illegal encoding, hold everything).
REQ-022 SHALL, on branch_flag=1 with stall[0]=0: pc<=branch_target, IF/ID<=bubble (one-cycle penalty).
REQ-023 SHALL ignore branch_flag while stall[0]=1.
REQ-024 SHALL, on flush=1: pc<=flush_pc, IF/ID<=bubble, regardless of stall or branch_flag.
REQ-025 SHALL apply priority rst > flush > stall hold > branch > sequential fetch.
REQ-026 SHALL always store pc with bit0 cleared (half-word aligned).
REQ-027 SHALL keep IF/ID latency = 1 cycle: instruction at rom_addr in cycle N appears on id_inst in cycle N+1.
REQ-028 SHALL keep IF/ID bubble when flush arrives in IDLE and move to RUN at pc=flush_pc.

Reset
REQ-029 SHALL on rst=1 at a clock edge set pc=0x0000, state=IDLE, id_pc=0x0000, id_inst=0x0000, id_valid=0, fetch_fault=0.
REQ-030 SHALL let rst override any in-flight flush, branch or stall in the same cycle.
REQ-031 SHALL hold rom_we at read level in all states including reset.

Configuration
REQ-032 SHALL provide macro FETCH_ALIGN_CHK_EN.
REQ-033 SHALL, with FETCH_ALIGN_CHK_EN defined, pulse fetch_fault=1 for one cycle after any accepted flush/branch whose target bit0=1; pc still loads target with bit0 cleared.
REQ-034 SHALL, without FETCH_ALIGN_CHK_EN, tie fetch_fault to 0 and silently clear target bit0.

Verification
REQ-035 SHALL cover: rst 1 cycle, then 4 free-run cycles, ROM word k = 0x1000+k -> rom_addr 0x0000,0x0002,0x0004; id_inst 0x1000,0x1001 with id_valid=1 from 2nd RUN cycle.
REQ-036 SHALL cover: branch_flag=1, target 0x0040 at pc=0x0006 -> next cycle id_valid=0, rom_addr=0x0040; following cycle id_inst=ROM[0x0040], id_pc=0x0040.
REQ-037 SHALL cover: stall=2'b01 two cycles at pc=0x0010 -> pc holds 0x0010, two bubbles, then fetch resumes at 0x0010 with no instruction lost.
REQ-038 SHALL cover: flush=1, flush_pc=0x0100 with stall=2'b11 and branch_flag=1 same cycle -> pc=0x0100, id_valid=0.
REQ-039 SHALL cover: pc=0xFFFE sequential fetch -> next rom_addr=0x0000, id_pc=0xFFFE.
REQ-040 SHALL cover: with FETCH_ALIGN_CHK_EN, branch_target=0x0023 -> pc=0x0022, fetch_fault=1 exactly one cycle; without macro fetch_fault stays 0.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC register, ROM address generation and the IF/ID pipeline register.
// Define FETCH_ALIGN_CHK_EN to report odd redirect targets on fetch_fault.
module if_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  stall,
    input  logic        flush,
    input  logic [15:0] flush_pc,
    input  logic        branch_flag,
    input  logic [15:0] branch_target,
    output logic [15:0] rom_addr,
    output logic        rom_we,
    input  logic [15:0] rom_inst,
    output logic [15:0] id_pc,
    output logic [15:0] id_inst,
    output logic        id_valid,
    output logic        fetch_fault
);

    localparam logic CHIP_READ = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] id_pc_q, id_pc_d;
    logic [15:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        fetch_fault_d;
    logic        fetch_fault_q;
    logic        redirect_odd;

    assign rom_we      = CHIP_READ;
    assign rom_addr    = (state_q == RUN) ? pc_q : 16'h0000;
    assign id_pc       = id_pc_q;
    assign id_inst     = id_inst_q;
    assign id_valid    = id_valid_q;
    assign fetch_fault = fetch_fault_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        id_pc_d      = id_pc_q;
        id_inst_d    = id_inst_q;
        id_valid_d   = id_valid_q;
        redirect_odd = 1'b0;

        if (flush) begin
            // Flush beats every stall and branch, in either state.
            state_d      = RUN;
            pc_d         = {flush_pc[15:1], 1'b0};
            id_pc_d      = pc_q;
            id_inst_d    = 16'h0000;
            id_valid_d   = 1'b0;
            redirect_odd = flush_pc[0];
        end else if (state_q == IDLE) begin
            state_d    = RUN;
            id_inst_d  = 16'h0000;
            id_valid_d = 1'b0;
        end else if (stall[1]) begin
            // 2'b10 is an illegal encoding and is held like 2'b11.
            state_d = RUN;
        end else if (stall[0]) begin
            id_pc_d    = pc_q;
            id_inst_d  = 16'h0000;
            id_valid_d = 1'b0;
        end else if (branch_flag) begin
            pc_d         = {branch_target[15:1], 1'b0};
            id_pc_d      = pc_q;
            id_inst_d    = 16'h0000;
            id_valid_d   = 1'b0;
            redirect_odd = branch_target[0];
        end else begin
            pc_d       = pc_q + 16'h0002;
            id_pc_d    = pc_q;
            id_inst_d  = rom_inst;
            id_valid_d = 1'b1;
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    assign fetch_fault_d = redirect_odd;
`else
    assign fetch_fault_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= 16'h0000;
            id_pc_q       <= 16'h0000;
            id_inst_q     <= 16'h0000;
            id_valid_q    <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_pc_q       <= id_pc_d;
            id_inst_q     <= id_inst_d;
            id_valid_q    <= id_valid_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch; the ROM returns 0x1000 + word index for every address.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [1:0]  stall;
    logic        flush;
    logic [15:0] flush_pc;
    logic        branch_flag;
    logic [15:0] branch_target;
    logic [15:0] rom_addr;
    logic        rom_we;
    logic [15:0] rom_inst;
    logic [15:0] id_pc;
    logic [15:0] id_inst;
    logic        id_valid;
    logic        fetch_fault;

    int assertCount = 0;
    int failCount   = 0;

`ifdef FETCH_ALIGN_CHK_EN
    localparam logic [15:0] EXP_FAULT = 16'h0001;
`else
    localparam logic [15:0] EXP_FAULT = 16'h0000;
`endif

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .rom_addr      (rom_addr),
        .rom_we        (rom_we),
        .rom_inst      (rom_inst),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid),
        .fetch_fault   (fetch_fault)
    );

    assign rom_inst = 16'h1000 + {1'b0, rom_addr[15:1]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One clock edge, then settle before the checks.
    task automatic applyStimulus(input logic [1:0] s, input logic f, input logic [15:0] fpc,
                                 input logic b, input logic [15:0] bt);
        stall         = s;
        flush         = f;
        flush_pc      = fpc;
        branch_flag   = b;
        branch_target = bt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("rst_rom_addr", rom_addr, 16'h0000);
        checkOutput("rst_id_pc", id_pc, 16'h0000);
        checkOutput("rst_id_inst", id_inst, 16'h0000);
        checkOutput("rst_id_valid", {15'd0, id_valid}, 16'h0000);
        checkOutput("rst_fault", {15'd0, fetch_fault}, 16'h0000);
        checkOutput("rst_rom_we", {15'd0, rom_we}, 16'h0000);
        rst = 1'b0;

        // Free run from address 0
        applyStimulus(2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("run1_rom_addr", rom_addr, 16'h0000);
        checkOutput("run1_valid", {15'd0, id_valid}, 16'h0000);
        applyStimulus(2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("run2_rom_addr", rom_addr, 16'h0002);
        checkOutput("run2_inst", id_inst, 16'h1000);
        checkOutput("run2_valid", {15'd0, id_valid}, 16'h0001);
        checkOutput("run2_pc", id_pc, 16'h0000);
        applyStimulus(2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("run3_rom_addr", rom_addr, 16'h0004);
        checkOutput("run3_inst", id_inst, 16'h1001);
        applyStimulus(2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("run4_rom_addr", rom_addr, 16'h0006);
        checkOutput("run4_inst", id_inst, 16'h1002);

        // Taken branch at pc 0x0006
        applyStimulus(2'b00, 1'b0, 16'h0000, 1'b1, 16'h0040);
        checkOutput("br_valid", {15'd0, id_valid}, 16'h0000);
        checkOutput("br_rom_addr", rom_addr, 16'h0040);
        applyStimulus(2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("br_inst", id_inst, 16'h1020);
        checkOutput("br_id_pc", id_pc, 16'h0040);
        checkOutput("br_after_addr", rom_addr, 16'h0042);

        // Stall-with-bubble at pc 0x0010; branch ignored while stalled
        applyStimulus(2'b00, 1'b0, 16'h0000, 1'b1, 16'h0010);
        checkOutput("st_setup_addr", rom_addr, 16'h0010);
        applyStimulus(2'b01, 1'b0, 16'h0000, 1'b1, 16'h0080);
        checkOutput("st1_addr", rom_addr, 16'h0010);
        checkOutput("st1_valid", {15'd0, id_valid}, 16'h0000);
        checkOutput("st1_id_pc", id_pc, 16'h0010);
        applyStimulus(2'b01, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("st2_addr", rom_addr, 16'h0010);
        checkOutput("st2_valid", {15'd0, id_valid}, 16'h0000);
        applyStimulus(2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("st_resume_inst", id_inst, 16'h1008);
        checkOutput("st_resume_pc", id_pc, 16'h0010);
        checkOutput("st_resume_valid", {15'd0, id_valid}, 16'h0001);
        checkOutput("st_resume_addr", rom_addr, 16'h0012);

        // Full hold, including the illegal 2'b10 encoding
        applyStimulus(2'b11, 1'b0, 16'h0000, 1'b1, 16'h0300);
        checkOutput("hold11_addr", rom_addr, 16'h0012);
        checkOutput("hold11_inst", id_inst, 16'h1008);
        checkOutput("hold11_valid", {15'd0, id_valid}, 16'h0001);
        applyStimulus(2'b10, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("hold10_addr", rom_addr, 16'h0012);
        checkOutput("hold10_inst", id_inst, 16'h1008);
        checkOutput("hold10_pc", id_pc, 16'h0010);

        // Flush wins over stall and branch
        applyStimulus(2'b11, 1'b1, 16'h0100, 1'b1, 16'h0200);
        checkOutput("fl_addr", rom_addr, 16'h0100);
        checkOutput("fl_valid", {15'd0, id_valid}, 16'h0000);
        applyStimulus(2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("fl_inst", id_inst, 16'h1080);
        checkOutput("fl_id_pc", id_pc, 16'h0100);

        // Wrap from 0xFFFE
        applyStimulus(2'b00, 1'b1, 16'hFFFE, 1'b0, 16'h0000);
        checkOutput("wrap_setup", rom_addr, 16'hFFFE);
        applyStimulus(2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("wrap_addr", rom_addr, 16'h0000);
        checkOutput("wrap_id_pc", id_pc, 16'hFFFE);
        checkOutput("wrap_inst", id_inst, 16'h8FFF);

        // Odd branch target
        applyStimulus(2'b00, 1'b0, 16'h0000, 1'b1, 16'h0023);
        checkOutput("odd_addr", rom_addr, 16'h0022);
        checkOutput("odd_fault", {15'd0, fetch_fault}, EXP_FAULT);
        applyStimulus(2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("odd_fault_drop", {15'd0, fetch_fault}, 16'h0000);
        checkOutput("odd_inst", id_inst, 16'h1011);
        checkOutput("odd_id_pc", id_pc, 16'h0022);

        // Reset overrides flush/branch, then flush during IDLE
        rst = 1'b1;
        applyStimulus(2'b11, 1'b1, 16'h0500, 1'b1, 16'h0600);
        checkOutput("rstov_addr", rom_addr, 16'h0000);
        checkOutput("rstov_inst", id_inst, 16'h0000);
        checkOutput("rstov_pc", id_pc, 16'h0000);
        checkOutput("rstov_valid", {15'd0, id_valid}, 16'h0000);
        rst = 1'b0;
        applyStimulus(2'b00, 1'b1, 16'h0300, 1'b0, 16'h0000);
        checkOutput("idlefl_addr", rom_addr, 16'h0300);
        checkOutput("idlefl_valid", {15'd0, id_valid}, 16'h0000);
        applyStimulus(2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("idlefl_inst", id_inst, 16'h1180);
        checkOutput("idlefl_id_pc", id_pc, 16'h0300);
        checkOutput("idlefl_valid2", {15'd0, id_valid}, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
